// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - multi-cycle RV32I-subset core with req/ack instruction and data ports
module multicycle_datapath #(
  parameter int XLEN = 32,
  parameter int IADDR_W = 8,
  parameter int DADDR_W = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_ack,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  input  logic [XLEN-1:0]    dmem_rdata,
  input  logic               dmem_ack,
  output logic [XLEN-1:0]    pc,
  output logic               retire,
  output logic               illegal
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t          state;
  logic [31:0]     ir;
  logic [XLEN-1:0] regs [32];
  logic [XLEN-1:0] a, b, imm, alu_out, target, mdr;

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  logic        is_r, is_addi, is_lw, is_sw, is_beq, is_bge, is_auipc, is_jal, legal;
  logic [31:0] imm32;

  // Instruction classification and immediate assembly from the latched IR
  always_comb begin
    is_r = 1'b0; is_addi = 1'b0; is_lw = 1'b0; is_sw = 1'b0;
    is_beq = 1'b0; is_bge = 1'b0; is_auipc = 1'b0; is_jal = 1'b0;
    imm32 = '0;
    case (opcode)
      7'b0110011: is_r = (funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b110))
                      || (funct7 == 7'b0100000 && funct3 == 3'b000);
      7'b0010011: begin is_addi = (funct3 == 3'b000); imm32 = {{20{ir[31]}}, ir[31:20]}; end
      7'b0000011: begin is_lw = (funct3 == 3'b010); imm32 = {{20{ir[31]}}, ir[31:20]}; end
      7'b0100011: begin is_sw = (funct3 == 3'b010); imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]}; end
      7'b1100011: begin
        is_beq = (funct3 == 3'b000);
        is_bge = (funct3 == 3'b101);
        imm32  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      end
      7'b0010111: begin is_auipc = 1'b1; imm32 = {ir[31:12], 12'b0}; end
      7'b1101111: begin is_jal = 1'b1; imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}; end
      default: ;
    endcase
    legal = is_r | is_addi | is_lw | is_sw | is_beq | is_bge | is_auipc | is_jal;
  end

  logic [XLEN-1:0] r_result, pc_plus4, br_next, jal_target;
  logic            br_taken;

  // Register-register ALU result and next-PC candidates for the EXEC step
  always_comb begin
    case (funct3)
      3'b111:  r_result = a & b;
      3'b110:  r_result = a | b;
      default: r_result = funct7[5] ? (a - b) : (a + b);
    endcase
    pc_plus4   = pc + XLEN'(4);
    jal_target = pc + imm;
    br_taken   = is_beq ? (a == b) : ($signed(a) >= $signed(b));
    br_next    = br_taken ? (pc + imm) : pc_plus4;
  end

  assign imem_addr  = pc[IADDR_W+1:2];
  assign dmem_addr  = alu_out[DADDR_W+1:2];
  assign dmem_wdata = b;

  // Control FSM with register file, datapath registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      imm      <= '0;
      alu_out  <= '0;
      target   <= '0;
      mdr      <= '0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      retire   <= 1'b0;
      illegal  <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          a   <= regs[rs1];
          b   <= regs[rs2];
          imm <= XLEN'($signed(imm32));
          if (legal) begin
            state <= S_EXEC;
          end else begin
            illegal <= 1'b1;
            state   <= S_HALT;
          end
        end
        S_EXEC: begin
          if (is_beq || is_bge) begin
            if (br_next[1:0] != 2'b00) begin
              illegal <= 1'b1;
              state   <= S_HALT;
            end else begin
              pc       <= br_next;
              retire   <= 1'b1;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
          end else if (is_jal) begin
            if (jal_target[1:0] != 2'b00) begin
              illegal <= 1'b1;
              state   <= S_HALT;
            end else begin
              alu_out <= pc_plus4;
              target  <= jal_target;
              state   <= S_WB;
            end
          end else if (is_lw || is_sw) begin
            alu_out  <= a + imm;
            dmem_req <= 1'b1;
            dmem_we  <= is_sw;
            state    <= S_MEM;
          end else if (is_auipc) begin
            alu_out <= pc + imm;
            state   <= S_WB;
          end else if (is_addi) begin
            alu_out <= a + imm;
            state   <= S_WB;
          end else begin
            alu_out <= r_result;
            state   <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (is_sw) begin
              pc       <= pc_plus4;
              retire   <= 1'b1;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end else begin
              mdr   <= dmem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (rd != 5'd0) regs[rd] <= is_lw ? mdr : alu_out;
          pc       <= is_jal ? target : pc_plus4;
          retire   <= 1'b1;
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb/tb_multicycle_datapath.sv - directed table plus random programs against an instruction-level model
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [7:0]  dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata, pc;
  logic        retire, illegal;

  multicycle_datapath dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .pc(pc), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // memory responders with programmable wait states
  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  int iwait = 0, dwait = 0, icnt = 0, dcnt = 0, rcnt;
  logic iblock = 1'b0;

  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];
  assign imem_ack   = imem_req && !iblock && (icnt >= iwait);
  assign dmem_ack   = dmem_req && (dcnt >= dwait);

  always @(posedge clk) begin
    icnt <= (!imem_req || imem_ack) ? 0 : icnt + 1;
    dcnt <= (!dmem_req || dmem_ack) ? 0 : dcnt + 1;
    if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rcnt <= 0;
    else if (retire) rcnt <= rcnt + 1;
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // instruction assemblers
  function automatic logic [31:0] e_i(input logic [11:0] im, input logic [4:0] s1, input logic [2:0] f3,
                                      input logic [4:0] d, input logic [6:0] op);
    return {im, s1, f3, d, op};
  endfunction
  function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                      input logic [2:0] f3, input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction
  function automatic logic [31:0] e_s(input logic [11:0] im, input logic [4:0] s2, input logic [4:0] s1);
    return {im[11:5], s2, s1, 3'b010, im[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] e_b(input logic [12:0] im, input logic [4:0] s2, input logic [4:0] s1,
                                      input logic [2:0] f3);
    return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] e_u(input logic [19:0] im, input logic [4:0] d, input logic [6:0] op);
    return {im, d, op};
  endfunction
  function automatic logic [31:0] e_j(input logic [20:0] im, input logic [4:0] d);
    return {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
  endfunction

  // instruction-set reference model
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [256];
  logic [31:0] m_pc;
  int          m_ret;
  logic        m_ill;

  task automatic run_model();
    logic [31:0] ins, va, vb, res, npc, addr, ii, is, ib, iu, ij;
    logic [4:0]  d, s1, s2;
    logic [2:0]  f3;
    logic [6:0]  op, f7;
    logic        wr;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = '0; m_ret = 0; m_ill = 1'b0;
    for (int step = 0; step < 1000 && !m_ill; step++) begin
      ins = imem[m_pc[9:2]];
      op = ins[6:0]; d = ins[11:7]; f3 = ins[14:12]; s1 = ins[19:15]; s2 = ins[24:20]; f7 = ins[31:25];
      ii = {{20{ins[31]}}, ins[31:20]};
      is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      iu = {ins[31:12], 12'b0};
      ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      va = m_regs[s1]; vb = m_regs[s2];
      npc = m_pc + 4; wr = 1'b0; res = '0;
      case (op)
        7'b0110011: begin
          wr = 1'b1;
          if (f7 == 7'h00 && f3 == 3'd0) res = va + vb;
          else if (f7 == 7'h20 && f3 == 3'd0) res = va - vb;
          else if (f7 == 7'h00 && f3 == 3'd7) res = va & vb;
          else if (f7 == 7'h00 && f3 == 3'd6) res = va | vb;
          else m_ill = 1'b1;
        end
        7'b0010011: if (f3 == 3'd0) begin wr = 1'b1; res = va + ii; end else m_ill = 1'b1;
        7'b0000011: if (f3 == 3'd2) begin wr = 1'b1; addr = va + ii; res = m_dmem[addr[9:2]]; end
                    else m_ill = 1'b1;
        7'b0100011: if (f3 == 3'd2) begin addr = va + is; m_dmem[addr[9:2]] = vb; end else m_ill = 1'b1;
        7'b1100011: begin
          if (f3 == 3'd0) begin if (va == vb) npc = m_pc + ib; end
          else if (f3 == 3'd5) begin if ($signed(va) >= $signed(vb)) npc = m_pc + ib; end
          else m_ill = 1'b1;
        end
        7'b0010111: begin wr = 1'b1; res = m_pc + iu; end
        7'b1101111: begin wr = 1'b1; res = m_pc + 4; npc = m_pc + ij; end
        default: m_ill = 1'b1;
      endcase
      if (!m_ill && npc[1:0] != 2'b00) m_ill = 1'b1;
      if (!m_ill) begin
        if (wr && d != 5'd0) m_regs[d] = res;
        m_pc = npc;
        m_ret++;
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  d, s1, s2;
    logic [11:0] off;
    logic [12:0] b13;
    logic [20:0] j21;
    logic [31:0] w;
    d = 5'($urandom_range(0, 15)); s1 = 5'($urandom_range(0, 15)); s2 = 5'($urandom_range(0, 15));
    off = {5'd0, 5'($urandom_range(0, 31)), 2'b00};
    b13 = ($urandom_range(0, 7) == 0) ? 13'd2 : 13'(4 * $urandom_range(1, 4));
    j21 = ($urandom_range(0, 7) == 0) ? 21'd2 : 21'(4 * $urandom_range(1, 4));
    case ($urandom_range(0, 19))
      0, 1, 2, 3, 16: w = e_i(12'($urandom), s1, 3'b000, d, 7'b0010011);
      4, 5, 6, 7, 17: begin
        case ($urandom_range(0, 4))
          0: w = e_r(7'h00, s2, s1, 3'b000, d);
          1: w = e_r(7'h20, s2, s1, 3'b000, d);
          2: w = e_r(7'h00, s2, s1, 3'b111, d);
          3: w = e_r(7'h00, s2, s1, 3'b110, d);
          default: w = e_r(7'($urandom_range(0, 127)), s2, s1, 3'($urandom), d);
        endcase
      end
      8, 9:    w = e_i(off, 5'd0, 3'b010, d, 7'b0000011);
      10, 11:  w = e_s(off, s2, 5'd0);
      12, 13:  w = e_b(b13, s2, s1, ($urandom_range(0, 1) == 1) ? 3'b101 : 3'b000);
      14:      w = e_u(20'($urandom), d, 7'b0010111);
      15:      w = e_j(j21, d);
      18:      w = e_b(13'd8, s2, s1, 3'b001);
      default: w = e_u(20'($urandom), d, 7'b0110111);
    endcase
    return w;
  endfunction

  task automatic wait_retire(output int lat);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (retire) begin lat = c; break; end
    end
  endtask

  task automatic wait_illegal(output int seen);
    seen = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (illegal) begin seen = 1; break; end
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    int          rd;
    logic [31:0] exp_val;
    logic [31:0] exp_pc;
    int          exp_lat;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int lat, found, reqs;
    logic [31:0] v;

    tbl[0]  = '{32'h00, e_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 1, 32'd5, 32'h04, 4};
    tbl[1]  = '{32'h04, e_i(12'hFFD, 5'd0, 3'b000, 5'd2, 7'b0010011), 2, 32'hFFFF_FFFD, 32'h08, 4};
    tbl[2]  = '{32'h08, e_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 3, 32'd2, 32'h0C, 4};
    tbl[3]  = '{32'h0C, e_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 4, 32'd8, 32'h10, 4};
    tbl[4]  = '{32'h10, e_b(13'd8, 5'd1, 5'd2, 3'b101), 0, 32'd0, 32'h14, 3};
    tbl[5]  = '{32'h14, e_b(13'd8, 5'd2, 5'd1, 3'b101), 0, 32'd0, 32'h1C, 3};
    tbl[6]  = '{32'h1C, e_s(12'd4, 5'd3, 5'd0), 3, 32'd2, 32'h20, 6};
    tbl[7]  = '{32'h20, e_j(21'd12, 5'd1), 1, 32'h24, 32'h2C, 4};
    tbl[8]  = '{32'h2C, e_u(20'd1, 5'd6, 7'b0010111), 6, 32'h102C, 32'h30, 4};
    tbl[9]  = '{32'h30, e_i(12'd4, 5'd0, 3'b010, 5'd5, 7'b0000011), 5, 32'd2, 32'h34, 7};
    tbl[10] = '{32'h34, e_i(12'd8, 5'd0, 3'b010, 5'd8, 7'b0000011), 8, 32'h7FFF_FFFF, 32'h38, 7};
    tbl[11] = '{32'h38, e_i(12'd12, 5'd0, 3'b010, 5'd9, 7'b0000011), 9, 32'h8000_0000, 32'h3C, 7};
    tbl[12] = '{32'h3C, e_b(13'd8, 5'd9, 5'd8, 3'b101), 0, 32'd0, 32'h44, 3};

    rst_n = 1'b0; iblock = 1'b1; iwait = 0; dwait = 2;
    for (int i = 0; i < 256; i++) begin imem[i] = 32'hFFFF_FFFF; dmem[i] <= 32'd0; end
    for (int i = 0; i < 13; i++) imem[tbl[i].addr[9:2]] = tbl[i].instr;
    imem[32'h44 >> 2] = e_b(13'd2, 5'd0, 5'd0, 3'b000);
    dmem[2] <= 32'h7FFF_FFFF;
    dmem[3] <= 32'h8000_0000;

    repeat (2) @(negedge clk);
    check("reset_pc", pc, 32'd0);
    check("reset_imem_req", 32'(imem_req), 32'd0);
    check("reset_dmem_req", 32'(dmem_req), 32'd0);
    check("reset_retire", 32'(retire), 32'd0);
    check("reset_illegal", 32'(illegal), 32'd0);

    // reset while a fetch is stalled
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("stalled_fetch_req", 32'(imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midfetch_reset_req", 32'(imem_req), 32'd0);
    check("midfetch_reset_pc", pc, 32'd0);
    @(negedge clk);
    iblock = 1'b0;
    rst_n = 1'b1;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (imem_req) begin found = 1; break; end
      @(negedge clk);
    end
    check("first_fetch_seen", 32'(found), 32'd1);
    check("first_fetch_addr", 32'(imem_addr), 32'd0);

    // directed program, zero-wait fetch, two-wait data
    for (int i = 0; i < 13; i++) begin
      wait_retire(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      check($sformatf("vec%0d_pc", i), pc, tbl[i].exp_pc);
      check($sformatf("vec%0d_x%0d", i, tbl[i].rd), dut.regs[tbl[i].rd], tbl[i].exp_val);
    end
    check("store_data_in_mem", dmem[1], 32'd2);

    // taken BEQ to a misaligned target halts without moving pc
    wait_illegal(found);
    check("misaligned_beq_illegal", 32'(found), 32'd1);
    check("misaligned_beq_pc", pc, 32'h44);
    reqs = 0;
    repeat (10) begin @(negedge clk); if (imem_req) reqs++; end
    check("halt_no_fetch", 32'(reqs), 32'd0);

    // misaligned JAL leaves rd untouched
    rst_n = 1'b0; iwait = 1; dwait = 0;
    for (int i = 0; i < 256; i++) imem[i] = 32'hFFFF_FFFF;
    imem[0] = e_i(12'd7, 5'd0, 3'b000, 5'd1, 7'b0010011);
    imem[1] = e_j(21'd2, 5'd1);
    @(negedge clk); rst_n = 1'b1;
    wait_illegal(found);
    repeat (2) @(negedge clk);
    check("jal_misaligned_illegal", 32'(found), 32'd1);
    check("jal_misaligned_pc", pc, 32'h4);
    check("jal_misaligned_x1", dut.regs[1], 32'd7);
    check("jal_misaligned_retires", 32'(rcnt), 32'd1);

    // all-ones word is illegal
    rst_n = 1'b0; iwait = 0;
    imem[0] = 32'hFFFF_FFFF;
    @(negedge clk); rst_n = 1'b1;
    wait_illegal(found);
    check("ones_word_illegal", 32'(found), 32'd1);
    check("ones_word_pc", pc, 32'd0);
    reqs = 0;
    repeat (8) begin @(negedge clk); if (imem_req) reqs++; end
    check("ones_word_no_fetch", 32'(reqs), 32'd0);

    // random programs against the model
    for (int t = 0; t < 20; t++) begin
      rst_n = 1'b0;
      iwait = $urandom_range(0, 2);
      dwait = $urandom_range(0, 2);
      for (int i = 0; i < 256; i++) begin
        imem[i] = (i < 24) ? rand_instr() : 32'hFFFF_FFFF;
        v = $urandom;
        dmem[i] <= v;
        m_dmem[i] = v;
      end
      run_model();
      @(negedge clk); rst_n = 1'b1;
      wait_illegal(found);
      repeat (3) @(negedge clk);
      check($sformatf("rand%0d_illegal", t), 32'(illegal), 32'(m_ill));
      check($sformatf("rand%0d_pc", t), pc, m_pc);
      check($sformatf("rand%0d_retired", t), 32'(rcnt), 32'(m_ret));
      for (int r = 1; r < 32; r++)
        check($sformatf("rand%0d_x%0d", t, r), dut.regs[r], m_regs[r]);
      for (int w = 0; w < 32; w++)
        check($sformatf("rand%0d_mem%0d", t, w), dmem[w], m_dmem[w]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multi-cycle RV32I-subset core: internal register file, ALU, decoder and a 5-state control FSM in one block.
- Successor to the single-cycle datapath. Instruction and data memories sit outside and are reached through req/ack handshakes that tolerate wait states.
- Adds JAL, correct signed BGE, illegal-instruction trap and a retire strobe.
- Sits between the instruction ROM and the data RAM in the CPU top.

Parameters:
- XLEN, 32, datapath/register width (≥32; immediates sign-extended to XLEN).
- IADDR_W, 8, instruction word-address width; imem_addr = pc[IADDR_W+1:2].
- DADDR_W, 8, data word-address width; dmem_addr = alu_out[DADDR_W+1:2].
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  IADDR_W  instruction word address.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- imem_ack  in  1  fetch complete; may assert in the same cycle as req.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1=store, 0=load; valid while dmem_req=1.
- dmem_addr  out  DADDR_W  data word address.
- dmem_wdata  out  XLEN  store data (rs2).
- dmem_rdata  in  XLEN  load data, valid when dmem_ack=1.
- dmem_ack  in  1  data access complete.
- pc  out  XLEN  current PC.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  sticky; set on unsupported opcode/funct or misaligned target.

Behaviour:
- Reset (async, immediate): pc=RESET_PC, state=FETCH, IR=0, all x-registers=0, imem_req=0, dmem_req=0, dmem_we=0, retire=0, illegal=0. Reset during a pending handshake drops req at once; a late ack is ignored.
- Supported instructions:
  - ADD, SUB, AND, OR (opcode 0110011, SUB is funct7[5]=1)
  - ADDI (0010011, f3=000)
  - LW (0000011, f3=010), SW (0100011, f3=010)
  - BEQ (1100011, f3=000), BGE (1100011, f3=101)
  - AUIPC (0010111), JAL (1101111)
  - Anything else is illegal.
- x0 reads as 0; writes to x0 are discarded.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, plus HALT.
- FETCH: imem_req=1 with imem_addr stable. On a clock edge with imem_ack=1: latch IR=imem_rdata, go to DECODE. Otherwise stay.
- DECODE: read rs1/rs2 into A/B; build immediate (I/S/B/U/J per type). Illegal → HALT, illegal=1.
- EXEC:
  - R/ADDI/LW/SW: alu_out = A op B/imm; loads and stores use A+imm.
  - AUIPC: alu_out = pc+imm. JAL: alu_out = pc+4, target = pc+imm.
  - BEQ taken when A==B; BGE taken when $signed(A) >= $signed(B), full-width compare with no overflow dependence.
  - Branches update pc (target or pc+4), pulse retire and go to FETCH.
  - LW/SW → MEM; all others → WB.
- MEM: dmem_req=1; dmem_we=1 for SW. On ack: LW latches MDR and goes to WB; SW sets pc+=4, pulses retire and goes to FETCH.
- WB: write rd (MDR for LW, else alu_out). JAL sets pc=target; everything else sets pc+=4. Pulse retire, go to FETCH.
- Misaligned target: if the computed next pc has [1:0]≠0, go to HALT with illegal=1. pc keeps the faulting instruction's address, and no register is written.
- HALT: no requests issued; leaves only on reset.
- Latency with zero-wait memory (ack in the same cycle as req):
  - branch: 3 cycles
  - SW, R-type, ADDI, AUIPC, JAL: 4 cycles
  - LW: 5 cycles
  - Each wait cycle adds 1.
- Req stays high until the cycle after ack is sampled, then drops for at least one cycle. Address and data are held stable while req=1.
- Arithmetic wraps modulo 2^XLEN; no overflow flag. pc+4 wraps at 2^XLEN.
- Memory address bits above the DADDR_W/IADDR_W windows are ignored.

Test Plan:
- Reset mid-FETCH with imem_ack held low → imem_req drops immediately, pc=0. After release, the first fetch is at addr 0.
- ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x1,x2, zero-wait memory → x3=2, x4=8, 4 retire pulses exactly 4 cycles apart, final pc=16.
- BGE x2,x1,+8 with x2=-3, x1=5 → not taken, pc+4. BGE x1,x2,+8 → taken. With x1=0x7FFFFFFF, x2=0x80000000 the branch is taken (checks signed compare at the overflow corner).
- SW x3,4(x0) then LW x5,4(x0), with dmem_ack delayed 2 cycles → dmem_we=1 on the store, x5=2, LW retires 7 cycles after its fetch starts.
- JAL x1,+12 at pc=0x20 → x1=0x24, pc=0x2C. AUIPC x6,1 at pc=0x2C → x6=0x102C.
- Word 0xFFFFFFFF fetched → illegal=1, HALT, no further imem_req. BEQ with offset +2 taken → HALT, illegal=1.
